// File: rtl/gray_decoder_rx_pkg.sv
// gray_pkg: shared FSM state type, error-counter width and Gray-to-binary helper.
package gray_pkg;
  typedef enum logic [1:0] {FILL, TRACK, FAULT} gray_rx_state_t;
  localparam int ERR_CNT_W = 8;
  // Pass the code zero-extended; unused upper bits decode to zero.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
endpackage

// File: rtl/gray_decoder_rx_if.sv
// gray_decoder_rx_if: Gray link receive-side bundle; err_cnt present only with GRAY_DEC_ERR_CNT_EN.
interface gray_decoder_rx_if #(parameter int WIDTH = 4);
  import gray_pkg::*;
  logic [WIDTH-1:0] gray_in;
  logic             clr_err;
  logic [WIDTH-1:0] bin_out;
  logic             bin_valid;
  logic             dir;
  logic             locked;
  logic             step_err;
`ifdef GRAY_DEC_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt;
  modport master(output gray_in, clr_err, input bin_out, bin_valid, dir, locked, step_err, err_cnt);
  modport slave(input gray_in, clr_err, output bin_out, bin_valid, dir, locked, step_err, err_cnt);
`else
  modport master(output gray_in, clr_err, input bin_out, bin_valid, dir, locked, step_err);
  modport slave(input gray_in, clr_err, output bin_out, bin_valid, dir, locked, step_err);
`endif
endinterface

// File: rtl/gray_decoder_rx_sync.sv
// gray_sync: SYNC_STAGES-deep plain flop chain bringing the Gray code into the receive clock domain.
module gray_sync #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_chain;
  always_ff @(posedge clock or negedge reset)
    if (!reset) r_chain <= '0;
    else        r_chain <= {r_chain[SYNC_STAGES-2:0], i_d};
  assign o_q = r_chain[SYNC_STAGES-1];
endmodule

// File: rtl/gray_decoder_rx.sv
// gray_decoder_rx: resynchronises and decodes a Gray counter, reports +/-1 steps and flags illegal jumps.
// Optional saturating illegal-step counter enabled by defining GRAY_DEC_ERR_CNT_EN.
module gray_decoder_rx
  import gray_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input logic               clock,
  input logic               reset,
  gray_decoder_rx_if.slave  bus
);
  localparam int FW = $clog2(SYNC_STAGES + 1);
  logic [WIDTH-1:0] w_gs, w_bin, w_d, r_bin;
  logic             w_up, w_dn, w_bad;
  logic             r_valid, r_dir, r_locked, r_err;
  logic [FW-1:0]    r_fill;
  gray_rx_state_t   r_state;
  gray_sync #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clock (clock),
    .reset (reset),
    .i_d   (bus.gray_in),
    .o_q   (w_gs)
  );
  assign w_bin = WIDTH'(gray2bin(32'(w_gs)));
  assign w_d   = w_bin - r_bin;
  assign w_up  = w_d == WIDTH'(1);
  assign w_dn  = w_d == '1;
  assign w_bad = !(w_d == '0 || w_up || w_dn);
  // FILL waits until the synchroniser holds a sampled value before the first load.
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      r_state  <= FILL;
      r_fill   <= '0;
      r_bin    <= '0;
      r_valid  <= 1'b0;
      r_dir    <= 1'b0;
      r_locked <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        FILL:
          if (r_fill == FW'(SYNC_STAGES)) begin
            r_bin    <= w_bin;
            r_state  <= TRACK;
            r_locked <= 1'b1;
          end else r_fill <= r_fill + 1'b1;
        TRACK:
          if (w_bad) begin
            r_bin    <= w_bin;
            r_err    <= 1'b1;
            r_state  <= FAULT;
            r_locked <= 1'b0;
          end else if (w_up || w_dn) begin
            r_bin   <= w_bin;
            r_valid <= 1'b1;
            r_dir   <= w_up;
          end
        FAULT: begin
          r_bin <= w_bin;
          if (bus.clr_err && !w_bad) begin
            r_err    <= 1'b0;
            r_state  <= TRACK;
            r_locked <= 1'b1;
          end
        end
        default: r_state <= FILL;
      endcase
    end
  assign bus.bin_out   = r_bin;
  assign bus.bin_valid = r_valid;
  assign bus.dir       = r_dir;
  assign bus.locked    = r_locked;
  assign bus.step_err  = r_err;
`ifdef GRAY_DEC_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] r_err_cnt;
  always_ff @(posedge clock or negedge reset)
    if (!reset) r_err_cnt <= '0;
    else if (r_state != FILL && w_bad && r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
  assign bus.err_cnt = r_err_cnt;
`endif
endmodule
